// File: rtl/lfsr_seq_stats.sv
// lfsr_seq_stats
//   Runs a Fibonacci-style LFSR for one full period (2^LFSR_W-1 steps) per run,
//   watches its output bit stream for a PAT_W-bit pattern and counts matches
//   in a saturating BCD counter. The count of the last completed period is
//   latched onto bcd/ovf at each period end.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           step enable; a step happens only on cycles with en=1 in RUN
//   start        pulse, begins a run from IDLE (ignored in RUN)
//   cont         1 = roll straight into the next period, 0 = stop after one
//   pattern      pattern to detect, MSB = oldest bit
//   overlap      1 = overlapping detection, 0 = restart after each match
//   lfsr_out     LFSR state MSB
//   seq_det      one-cycle pulse, cycle after a matching step
//   period_done  one-cycle pulse, cycle after the last step of a period
//   busy         high while in RUN
//   bcd          latched match count, digit 0 in [3:0]
//   ovf          latched saturation flag
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; LFSR and latched results hold
// RUN   | stepping on en; one period = 2^LFSR_W-1 steps
module lfsr_seq_stats #(
    parameter int unsigned       LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = 8'hB8,
    parameter logic [LFSR_W-1:0] SEED   = 8'h01,
    parameter int unsigned       PAT_W  = 4,
    parameter int unsigned       DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic                  cont,
    input  logic [PAT_W-1:0]      pattern,
    input  logic                  overlap,
    output logic                  lfsr_out,
    output logic                  seq_det,
    output logic                  period_done,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_W);
    localparam logic [LFSR_W-1:0]   STEP_ALL  = '1;
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [LFSR_W-1:0]   lfsr;
    logic [PAT_W-1:0]    history;
    logic [FILL_W-1:0]   fill;
    logic [4*DIGITS-1:0] cnt_live;
    logic                ovf_live;
    logic [LFSR_W-1:0]   steps_left;
    logic [PAT_W-1:0]    pat_cap;
    logic                ovl_cap;

    logic                fb;
    logic [PAT_W-1:0]    hist_next;
    logic [FILL_W-1:0]   fill_inc;
    logic [FILL_W-1:0]   fill_next;
    logic                match;
    logic [4*DIGITS-1:0] cnt_after;
    logic                ovf_after;
    logic                terminal;

    // Decimal increment with ripple carry; caller guarantees v is not all 9s.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign lfsr_out = lfsr[LFSR_W-1];

    always_comb begin
        fb        = ^(lfsr & TAPS);
        hist_next = PAT_W'({history, lfsr[LFSR_W-1]});
        fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match     = (fill_inc == FILL_FULL) && (hist_next == pat_cap);
        // Non-overlapping mode needs a fresh PAT_W bits before the next match.
        fill_next = (match && !ovl_cap) ? '0 : fill_inc;
        cnt_after = cnt_live;
        ovf_after = ovf_live;
        if (match) begin
            if (cnt_live == ALL_NINES) begin
                ovf_after = 1'b1;
            end else begin
                cnt_after = bcd_inc(cnt_live);
            end
        end
        // steps_left is loaded with 2^LFSR_W-1, so value 1 marks the last step.
        terminal = (steps_left == LFSR_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= SEED;
            history     <= '0;
            fill        <= '0;
            cnt_live    <= '0;
            ovf_live    <= 1'b0;
            steps_left  <= '0;
            pat_cap     <= '0;
            ovl_cap     <= 1'b0;
            seq_det     <= 1'b0;
            period_done <= 1'b0;
            busy        <= 1'b0;
            bcd         <= '0;
            ovf         <= 1'b0;
        end else begin
            seq_det     <= 1'b0;
            period_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr       <= SEED;
                        history    <= '0;
                        fill       <= '0;
                        cnt_live   <= '0;
                        ovf_live   <= 1'b0;
                        steps_left <= STEP_ALL;
                        pat_cap    <= pattern;
                        ovl_cap    <= overlap;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (en) begin
                        lfsr    <= {lfsr[LFSR_W-2:0], fb};
                        history <= hist_next;
                        fill    <= fill_next;
                        seq_det <= match;
                        if (terminal) begin
                            bcd         <= cnt_after;
                            ovf         <= ovf_after;
                            period_done <= 1'b1;
                            cnt_live    <= '0;
                            ovf_live    <= 1'b0;
                            steps_left  <= STEP_ALL;
                            if (cont) begin
                                pat_cap <= pattern;
                                ovl_cap <= overlap;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt_live   <= cnt_after;
                            ovf_live   <= ovf_after;
                            steps_left <= steps_left - LFSR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_seq_stats.sv
module tb_lfsr_seq_stats;

    typedef struct {
        int bcd;
        int ovf;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // a: defaults with PAT_W=1
    logic        a_en = 1'b0, a_start = 1'b0, a_cont = 1'b0, a_overlap = 1'b1;
    logic [0:0]  a_pattern = 1'b1;
    logic        a_lfsr_out, a_seq_det, a_period_done, a_busy, a_ovf;
    logic [15:0] a_bcd;
    // b: DIGITS=1, PAT_W=1
    logic        b_en = 1'b0, b_start = 1'b0, b_cont = 1'b0, b_overlap = 1'b0;
    logic [0:0]  b_pattern = 1'b1;
    logic        b_lfsr_out, b_seq_det, b_period_done, b_busy, b_ovf;
    logic [3:0]  b_bcd;
    // c: PAT_W=2
    logic        c_en = 1'b0, c_start = 1'b0, c_cont = 1'b0, c_overlap = 1'b1;
    logic [1:0]  c_pattern = 2'b11;
    logic        c_lfsr_out, c_seq_det, c_period_done, c_busy, c_ovf;
    logic [15:0] c_bcd;

    lfsr_seq_stats #(.PAT_W(1)) dut_a (
        .clk(clk), .reset(reset), .en(a_en), .start(a_start), .cont(a_cont),
        .pattern(a_pattern), .overlap(a_overlap), .lfsr_out(a_lfsr_out),
        .seq_det(a_seq_det), .period_done(a_period_done), .busy(a_busy),
        .bcd(a_bcd), .ovf(a_ovf));

    lfsr_seq_stats #(.PAT_W(1), .DIGITS(1)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .start(b_start), .cont(b_cont),
        .pattern(b_pattern), .overlap(b_overlap), .lfsr_out(b_lfsr_out),
        .seq_det(b_seq_det), .period_done(b_period_done), .busy(b_busy),
        .bcd(b_bcd), .ovf(b_ovf));

    lfsr_seq_stats #(.PAT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(c_en), .start(c_start), .cont(c_cont),
        .pattern(c_pattern), .overlap(c_overlap), .lfsr_out(c_lfsr_out),
        .seq_det(c_seq_det), .period_done(c_period_done), .busy(c_busy),
        .bcd(c_bcd), .ovf(c_ovf));

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int a_seen = 0, b_seen = 0, c_seen = 0;
    int c_last_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 8-bit LFSR with taps B8, one full period of 255 steps,
    // match counted on a sliding window of the emitted bits.
    task automatic model_period(input int pat_w, input int digits, input int pat, input int ovl,
                                inout int s, inout int hist, inout int fill, output exp_t e);
        int m;
        int lim;
        int v;
        int r;
        int bit_o;
        m = 0;
        for (int k = 0; k < 255; k++) begin
            bit_o = (s >> 7) & 1;
            s     = ((s << 1) | ($countones(s & 'hB8) & 1)) & 'hFF;
            hist  = ((hist << 1) | bit_o) & ((1 << pat_w) - 1);
            if (fill < pat_w) fill++;
            if (fill == pat_w && hist == pat) begin
                m++;
                if (ovl == 0) fill = 0;
            end
        end
        lim = 1;
        for (int d = 0; d < digits; d++) lim *= 10;
        e.cnt = m;
        e.ovf = (m >= lim) ? 1 : 0;
        v = (m >= lim) ? lim - 1 : m;
        r = 0;
        for (int d = 0; d < digits; d++) begin
            r = r | ((v % 10) << (4 * d));
            v = v / 10;
        end
        e.bcd = r;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) a_seen = 0;
        else if (a_seq_det) a_seen++;
        if (a_period_done) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_period", 32'(a_period_done), 32'd0);
            end else begin
                e = q_a.pop_front();
                check("a_bcd", 32'(a_bcd), e.bcd);
                check("a_ovf", 32'(a_ovf), e.ovf);
                check("a_seq_det_count", a_seen, e.cnt);
            end
            a_seen = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) b_seen = 0;
        else if (b_seq_det) b_seen++;
        if (b_period_done) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_period", 32'(b_period_done), 32'd0);
            end else begin
                e = q_b.pop_front();
                check("b_bcd", 32'(b_bcd), e.bcd);
                check("b_ovf", 32'(b_ovf), e.ovf);
                check("b_seq_det_count", b_seen, e.cnt);
            end
            b_seen = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) c_seen = 0;
        else if (c_seq_det) c_seen++;
        if (c_period_done) begin
            if (q_c.size() == 0) begin
                check("c_unexpected_period", 32'(c_period_done), 32'd0);
            end else begin
                e = q_c.pop_front();
                check("c_bcd", 32'(c_bcd), e.bcd);
                check("c_ovf", 32'(c_ovf), e.ovf);
                check("c_seq_det_count", c_seen, e.cnt);
            end
            c_last_cnt = c_seen;
            c_seen     = 0;
        end
    end

    task automatic run_a(input int pat, input bit tog, input int exp_cycles);
        exp_t e;
        int s, h, f, n;
        s = 1; h = 0; f = 0; n = 0;
        model_period(1, 4, pat, 1, s, h, f, e);
        q_a.push_back(e);
        @(posedge clk); #1;
        a_pattern = 1'(pat); a_cont = 1'b0; a_en = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        check("a_busy_run", 32'(a_busy), 32'd1);
        if (tog) a_en = 1'b0;
        while (!a_period_done && n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (tog) a_en = ~a_en;
        end
        a_en = 1'b1;
        check("a_period_cycles", n, exp_cycles);
        check("a_busy_after", 32'(a_busy), 32'd0);
        check("a_lfsr_out_after", 32'(a_lfsr_out), 32'd0);
        @(negedge clk); #1;
    endtask

    task automatic run_b();
        exp_t e1, e2;
        int s, h, f, n;
        s = 1; h = 0; f = 0; n = 0;
        model_period(1, 1, 1, 0, s, h, f, e1);
        model_period(1, 1, 1, 0, s, h, f, e2);
        q_b.push_back(e1);
        q_b.push_back(e2);
        @(posedge clk); #1;
        b_pattern = 1'b1; b_overlap = 1'b0; b_cont = 1'b1; b_en = 1'b1; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        while (!b_period_done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_first_period_steps", n, 255);
        check("b_busy_cont", 32'(b_busy), 32'd1);
        b_cont = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!b_period_done && n < 2000);
        check("b_period_spacing", n, 255);
        check("b_busy_after", 32'(b_busy), 32'd0);
        @(negedge clk); #1;
    endtask

    task automatic run_c(input int pat, input int ovl, input bit rnd);
        exp_t e;
        int s, h, f, n, steps;
        s = 1; h = 0; f = 0; n = 0; steps = 0;
        model_period(2, 4, pat, ovl, s, h, f, e);
        q_c.push_back(e);
        @(posedge clk); #1;
        c_pattern = 2'(pat); c_overlap = 1'(ovl); c_cont = 1'b0; c_en = 1'b1; c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0;
        c_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!c_period_done && n < 4000) begin
            if (rnd) begin
                // captured values must shield the run from these
                c_pattern = 2'($urandom_range(0, 3));
                c_overlap = 1'($urandom_range(0, 1));
                c_start   = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            if (c_en) steps++;
            #1;
            n++;
            c_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        c_start = 1'b0;
        check("c_steps", steps, 255);
        check("c_busy_after", 32'(c_busy), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_ov1, cnt_ov0, n;
        #12;
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_bcd", 32'(a_bcd), 32'd0);
        check("rst_lfsr_out", 32'(a_lfsr_out), 32'd0);
        check("rst_seq_det", 32'(a_seq_det), 32'd0);
        check("rst_period_done", 32'(a_period_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(a_busy), 32'd0);
            check("idle_lfsr_out", 32'(a_lfsr_out), 32'd0);
            check("idle_bcd", 32'(a_bcd), 32'd0);
            check("idle_seq_det", 32'(a_seq_det | b_seq_det | c_seq_det), 32'd0);
            check("idle_period_done", 32'(a_period_done | b_period_done | c_period_done), 32'd0);
        end

        run_a(1, 1'b0, 255);
        run_a(0, 1'b0, 255);
        run_a(1, 1'b1, 510);

        // abort a run at step 100; results must clear, not hold 0128
        @(posedge clk); #1;
        a_pattern = 1'b1; a_en = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_bcd", 32'(a_bcd), 32'd0);
        check("abort_ovf", 32'(a_ovf), 32'd0);
        check("abort_seq_det", 32'(a_seq_det), 32'd0);
        check("abort_period_done", 32'(a_period_done), 32'd0);
        check("abort_lfsr_out", 32'(a_lfsr_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_a(1, 1'b0, 255);

        run_b();

        run_c(3, 1, 1'b0);
        cnt_ov1 = c_last_cnt;
        run_c(3, 0, 1'b0);
        cnt_ov0 = c_last_cnt;
        check("c_overlap0_lower", 32'(cnt_ov0 < cnt_ov1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run_c(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) @(posedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        check("c_queue_drained", q_c.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
